// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: scoreboard-based RAW hazard detection that stalls fetch and issues NOP bubbles
module hazard_stall_ctrl #(
  parameter int          DEPTH = 3,
  parameter logic [31:0] NOP   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrIn,
  input  logic        InstrValid,
  output logic [31:0] InstrOut,
  output logic        Stall,
  output logic        Busy,
  output logic [15:0] BubbleCount
);
  typedef enum logic {RUN, STALL} state_t;
  state_t                state;
  logic [DEPTH-1:0]      sb_v;
  logic [DEPTH-1:0][4:0] sb_reg;
  logic [15:0]           bubble_count;
  logic [4:0]            rd, rs1, rs2;
  logic                  itype, writes, hazard;
  assign rd     = InstrIn[25:21];
  assign rs1    = InstrIn[20:16];
  assign rs2    = InstrIn[15:11];
  assign itype  = InstrIn[29];
  assign writes = InstrValid && InstrIn != NOP && rd != 5'd0;
  // a used nonzero source matching any valid in-flight destination is a RAW hazard
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < DEPTH; k++)
      hazard = hazard | (sb_v[k] & ((rs1 != 5'd0 && sb_reg[k] == rs1) | (!itype && rs2 != 5'd0 && sb_reg[k] == rs2)));
    hazard = hazard & InstrValid & rst;
  end
  assign Stall       = hazard;
  assign InstrOut    = (rst && InstrValid && !hazard) ? InstrIn : NOP;
  assign Busy        = state == STALL;
  assign BubbleCount = bubble_count;
  // shift the scoreboard one stage, track stall state and count inserted bubbles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sb_v         <= '0;
      sb_reg       <= '0;
      state        <= RUN;
      bubble_count <= '0;
    end else begin
      sb_v         <= {sb_v[DEPTH-2:0], !hazard && writes};
      sb_reg       <= {sb_reg[DEPTH-2:0], rd};
      state        <= hazard ? STALL : RUN;
      bubble_count <= (hazard && bubble_count != 16'hFFFF) ? bubble_count + 16'd1 : bubble_count;
    end
  end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed and randomized checks against a register-ready-time model
module tb_hazard_stall_ctrl;
  localparam int DEPTH = 3;
  localparam logic [31:0] ADDI_R1 = 32'h7421000A;
  localparam logic [31:0] ADD_R3  = 32'h54611000;
  localparam logic [31:0] IND     = 32'h546A5800;
  localparam logic [31:0] ADDI_R2 = 32'h74450000;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] InstrIn = '0;
  logic        InstrValid = 1'b0;
  logic [31:0] InstrOut;
  logic        Stall, Busy;
  logic [15:0] BubbleCount;
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int ready[32];
  int exp_cnt = 0;
  bit exp_busy = 1'b0;
  always #5 clk = ~clk;
  hazard_stall_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .InstrIn(InstrIn), .InstrValid(InstrValid),
    .InstrOut(InstrOut), .Stall(Stall), .Busy(Busy), .BubbleCount(BubbleCount)
  );
  // a register is unavailable until cycle ready[r]; a source read before then must wait
  function automatic bit m_hazard(input logic [31:0] i, input logic v);
    int s1, s2;
    s1 = int'(i[20:16]);
    s2 = int'(i[15:11]);
    if (!v) return 1'b0;
    return (s1 != 0 && ready[s1] > cyc) || (!i[29] && s2 != 0 && ready[s2] > cyc);
  endfunction
  function automatic logic [31:0] m_out(input logic [31:0] i, input logic v);
    return (v && !m_hazard(i, v)) ? i : 32'h0;
  endfunction
  task automatic m_reset();
    foreach (ready[r]) ready[r] = 0;
    exp_cnt = 0;
    exp_busy = 1'b0;
  endtask
  task automatic tick();
    bit h;
    int d;
    h = m_hazard(InstrIn, InstrValid);
    d = int'(InstrIn[25:21]);
    if (!h && InstrValid && InstrIn != 32'h0 && d != 0 && ready[d] < cyc + DEPTH + 1) ready[d] = cyc + DEPTH + 1;
    if (h && exp_cnt < 65535) exp_cnt++;
    exp_busy = h;
    cyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic v);
    InstrIn = i;
    InstrValid = v;
    #1;
  endtask
  task automatic idle(input int n);
    drive(32'h0, 1'b0);
    repeat (n) tick();
  endtask
  task automatic issue(input logic [31:0] i, output int b, output logic [31:0] o);
    b = 0;
    drive(i, 1'b1);
    while (Stall && b < 10) begin
      b++;
      tick();
    end
    o = InstrOut;
    tick();
  endtask
  task automatic test_reset();
    rst = 1'b0;
    drive(ADDI_R1, 1'b1);
    n_checks++; if (InstrOut !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %h want 00000000", InstrOut); end
    n_checks++; if (Stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", Stall); end
    n_checks++; if (Busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_checks++; if (BubbleCount !== 16'h0) begin n_fail++; $display("FAIL reset_count: got %h want 0000", BubbleCount); end
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    n_checks++; if (InstrOut !== ADDI_R1 || Stall !== 1'b0) begin n_fail++; $display("FAIL reset_release: out=%h stall=%b want %h 0", InstrOut, Stall, ADDI_R1); end
    tick();
  endtask
  task automatic test_back_to_back();
    int b;
    bit done;
    b = 0;
    drive(ADD_R3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if (InstrOut !== m_out(InstrIn, InstrValid) || Stall !== m_hazard(InstrIn, InstrValid) || Stall !== (i < 3))
        begin n_fail++; $display("FAIL b2b_cycle%0d: out=%h stall=%b want %h %b", i, InstrOut, Stall, m_out(InstrIn, InstrValid), i < 3); end
      n_checks++;
      if (Busy !== exp_busy || Busy !== (i > 0))
        begin n_fail++; $display("FAIL b2b_busy%0d: got %b want %b", i, Busy, i > 0); end
      if (Stall) b++;
      done = !Stall;
      tick();
      if (done) break;
    end
    n_checks++; if (b != 3) begin n_fail++; $display("FAIL b2b_bubbles: got %0d want 3", b); end
    n_checks++; if (BubbleCount !== 16'd3 || BubbleCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL b2b_count: got %0d want 3", BubbleCount); end
  endtask
  task automatic test_independent();
    int b1, b2;
    logic [31:0] o1, o2;
    idle(4);
    issue(ADDI_R1, b1, o1);
    issue(IND, b2, o2);
    n_checks++; if (b1 != 0 || b2 != 0) begin n_fail++; $display("FAIL indep_bubbles: got %0d,%0d want 0,0", b1, b2); end
    n_checks++; if (o1 !== ADDI_R1 || o2 !== IND) begin n_fail++; $display("FAIL indep_out: got %h,%h want %h,%h", o1, o2, ADDI_R1, IND); end
  endtask
  task automatic test_distance();
    int b1, b2, b3, b4, b5;
    logic [31:0] o;
    idle(4);
    issue(ADDI_R1, b1, o);
    issue(IND, b2, o);
    issue(ADD_R3, b3, o);
    n_checks++; if (b3 != 2 || o !== ADD_R3) begin n_fail++; $display("FAIL dist2: got %0d bubbles out=%h want 2 %h", b3, o, ADD_R3); end
    issue(32'h74050005, b4, o);
    issue(32'h54800000, b5, o);
    n_checks++; if (b4 != 0 || b5 != 0) begin n_fail++; $display("FAIL r0_dep: got %0d,%0d want 0,0", b4, b5); end
  endtask
  task automatic test_imm_alias();
    int b1, b2, b3;
    logic [31:0] o;
    idle(4);
    issue(ADDI_R2, b1, o);
    issue(32'h74210002, b2, o);
    issue(32'h74C51000, b3, o);
    n_checks++; if (b2 != 0 || b3 != 0) begin n_fail++; $display("FAIL imm_alias: got %0d,%0d want 0,0", b2, b3); end
  endtask
  task automatic test_two_sources();
    int b;
    logic [31:0] o;
    idle(4);
    issue(ADDI_R1, b, o);
    issue(ADDI_R2, b, o);
    issue(ADD_R3, b, o);
    n_checks++; if (b != 3) begin n_fail++; $display("FAIL two_sources: got %0d want 3", b); end
  endtask
  task automatic test_random();
    logic [31:0] r;
    bit hold;
    hold = 1'b0;
    idle(4);
    for (int i = 0; i < 400; i++) begin
      if (!hold) begin
        r = $urandom;
        r[25:21] = 5'($urandom_range(0, 3));
        r[20:16] = 5'($urandom_range(0, 3));
        r[15:11] = 5'($urandom_range(0, 3));
        if ($urandom_range(0, 9) == 0) r = 32'h0;
        drive(r, $urandom_range(0, 4) != 0);
      end
      n_checks++;
      if (InstrOut !== m_out(InstrIn, InstrValid) || Stall !== m_hazard(InstrIn, InstrValid))
        begin n_fail++; $display("FAIL random_out cyc%0d in=%h: out=%h stall=%b want %h %b", i, InstrIn, InstrOut, Stall, m_out(InstrIn, InstrValid), m_hazard(InstrIn, InstrValid)); end
      n_checks++;
      if (Busy !== exp_busy || BubbleCount !== 16'(exp_cnt))
        begin n_fail++; $display("FAIL random_state cyc%0d: busy=%b count=%0d want %b %0d", i, Busy, BubbleCount, exp_busy, exp_cnt); end
      hold = m_hazard(InstrIn, InstrValid);
      tick();
    end
  endtask
  task automatic test_saturation_and_reset();
    int b;
    logic [31:0] o;
    idle(4);
    dut.bubble_count = 16'hFFFC;
    exp_cnt = 65532;
    issue(ADDI_R1, b, o);
    issue(ADD_R3, b, o);
    n_checks++; if (BubbleCount !== 16'hFFFF || BubbleCount !== 16'(exp_cnt)) begin n_fail++; $display("FAIL sat_reach: got %h want ffff", BubbleCount); end
    idle(4);
    issue(ADDI_R1, b, o);
    issue(ADD_R3, b, o);
    n_checks++; if (BubbleCount !== 16'hFFFF || b != 3) begin n_fail++; $display("FAIL sat_hold: got %h bubbles=%0d want ffff 3", BubbleCount, b); end
    idle(4);
    issue(ADDI_R1, b, o);
    drive(ADD_R3, 1'b1);
    tick();
    n_checks++; if (Stall !== 1'b1 || Busy !== 1'b1) begin n_fail++; $display("FAIL midstall_pre: stall=%b busy=%b want 1 1", Stall, Busy); end
    rst = 1'b0;
    #1;
    n_checks++; if (Stall !== 1'b0 || InstrOut !== 32'h0) begin n_fail++; $display("FAIL midstall_rst_out: stall=%b out=%h want 0 00000000", Stall, InstrOut); end
    n_checks++; if (Busy !== 1'b0 || BubbleCount !== 16'h0) begin n_fail++; $display("FAIL midstall_rst_state: busy=%b count=%h want 0 0000", Busy, BubbleCount); end
    @(negedge clk);
    rst = 1'b1;
    m_reset();
    #1;
    n_checks++; if (Stall !== 1'b0 || InstrOut !== ADD_R3) begin n_fail++; $display("FAIL midstall_release: stall=%b out=%h want 0 %h", Stall, InstrOut, ADD_R3); end
    tick();
    n_checks++; if (Busy !== 1'b0 || BubbleCount !== 16'h0) begin n_fail++; $display("FAIL post_release: busy=%b count=%h want 0 0000", Busy, BubbleCount); end
  endtask
  initial begin
    test_reset();
    test_back_to_back();
    test_independent();
    test_distance();
    test_imm_alias();
    test_two_sources();
    test_random();
    test_saturation_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
